// File: rtl/posit_encoder_pipe.sv
// posit_encoder_pipe
//   Multi-lane, two-stage pipelined posit encoder with a valid/ready handshake.
//   Each lane turns {sign, signed scale k*2^es+e, normalised mantissa} into an
//   n-bit posit. Rounding is RNE or RTZ. Non-zero magnitudes saturate to
//   minpos/maxpos and never become 0 or NaR.
//   Stage 1: builds the regime, packs the fields, right-shifts them, and keeps the guard and sticky bits.
//   Stage 2: rounds, saturates, negates, and applies the NaR/zero overrides.
//
// Ports
//   clk_i, rst_ni              clock, async active-low reset
//   in_valid_i / in_ready_o    input handshake
//   round_mode_i               0 = RNE, 1 = RTZ (per beat)
//   tag_i / tag_o              sideband tag, passed through unchanged
//   nar_i, sign_i              per-lane NaR flag and sign
//   rg_exp_i                   per-lane two's-complement scale, lane i in slice i
//   mant_norm_i                per-lane mantissa, MSB = implicit bit (0 => zero)
//   out_valid_o / out_ready_i  output handshake
//   result_o                   per-lane posits, lane i in slice i
module posit_encoder_pipe #(
  parameter int n          = 16,
  parameter int es         = 1,
  parameter int NUM_LANES  = 4,
  parameter int TAG_WIDTH  = 4,
  parameter int nd         = $clog2(n - 1),
  parameter int EXP_WIDTH  = nd + es,
  parameter int MANT_WIDTH = n - es - 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic                                 round_mode_i,
  input  logic [TAG_WIDTH-1:0]                 tag_i,
  input  logic [NUM_LANES-1:0]                 nar_i,
  input  logic [NUM_LANES-1:0]                 sign_i,
  input  logic [NUM_LANES*(EXP_WIDTH+1)-1:0]   rg_exp_i,
  input  logic [NUM_LANES*(MANT_WIDTH+1)-1:0]  mant_norm_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [TAG_WIDTH-1:0]                 tag_o,
  output logic [NUM_LANES*n-1:0]               result_o
);

  localparam int SW  = n - 1;          // field string kept after the sign bit
  localparam int WW  = 2 * n;          // shift workspace, wide enough to lose nothing
  localparam int SCW = EXP_WIDTH + 1;  // signed scale width
  localparam int MW  = MANT_WIDTH + 1;

  localparam logic signed [SCW-1:0] K_MAX = SCW'(n - 2);
  localparam logic signed [SCW-1:0] K_MIN = -K_MAX;
  localparam logic [n-1:0] MAXPOS = {1'b0, {(n-1){1'b1}}};
  localparam logic [n-1:0] MINPOS = n'(1);
  localparam logic [n-1:0] NAR    = {1'b1, {(n-1){1'b0}}};

  logic adv;
  assign adv        = out_ready_i | ~out_valid_o;

  // ---------------- stage 1: regime build, pack, shift ----------------
  logic                           s1_valid;
  logic [TAG_WIDTH-1:0]           s1_tag;
  logic                           s1_rm;
  logic [NUM_LANES-1:0]           s1_nar, s1_sign, s1_zero, s1_sat_hi, s1_sat_lo;
  logic [NUM_LANES-1:0]           s1_guard, s1_sticky;
  logic [NUM_LANES-1:0][SW-1:0]   s1_field;

  assign in_ready_o = adv | ~s1_valid;

  logic [NUM_LANES-1:0][SW-1:0]   field_d;
  logic [NUM_LANES-1:0]           guard_d, sticky_d, sat_hi_d, sat_lo_d, zero_d;

  logic signed [SCW-1:0] scale, k;
  logic [SCW-1:0]        sh;
  logic [SW-1:0]         base;
  logic [WW-1:0]         wide;

  always_comb begin
    field_d  = '0;
    guard_d  = '0;
    sticky_d = '0;
    sat_hi_d = '0;
    sat_lo_d = '0;
    zero_d   = '0;
    scale    = '0;
    k        = '0;
    sh       = '0;
    base     = '0;
    wide     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      scale = rg_exp_i[i*SCW +: SCW];
      k     = scale >>> es;
      // k >= 0: "10" shifted right by k with ones fill -> k+1 ones then 0.
      // k <  0: "01" shifted right by -k-1 (= ~k) with zero fill -> -k zeros then 1.
      sh    = k[SCW-1] ? ~k : k;
      base  = {~k[SCW-1], k[SCW-1], scale[es-1:0], mant_norm_i[i*MW +: MANT_WIDTH]};
      wide  = {base, {(WW-SW){1'b0}}} >> sh;
      if (!k[SCW-1]) wide = wide | ~({WW{1'b1}} >> sh);
      field_d[i]  = wide[WW-1 -: SW];
      guard_d[i]  = wide[WW-SW-1];
      sticky_d[i] = |wide[WW-SW-2:0];
      sat_hi_d[i] = k > K_MAX;
      sat_lo_d[i] = k < K_MIN;
      zero_d[i]   = ~mant_norm_i[i*MW + MANT_WIDTH];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid  <= 1'b0;
      s1_tag    <= '0;
      s1_rm     <= 1'b0;
      s1_nar    <= '0;
      s1_sign   <= '0;
      s1_zero   <= '0;
      s1_sat_hi <= '0;
      s1_sat_lo <= '0;
      s1_guard  <= '0;
      s1_sticky <= '0;
      s1_field  <= '0;
    end else if (in_ready_o) begin
      s1_valid <= in_valid_i;
      if (in_valid_i) begin
        s1_tag    <= tag_i;
        s1_rm     <= round_mode_i;
        s1_nar    <= nar_i;
        s1_sign   <= sign_i;
        s1_zero   <= zero_d;
        s1_sat_hi <= sat_hi_d;
        s1_sat_lo <= sat_lo_d;
        s1_guard  <= guard_d;
        s1_sticky <= sticky_d;
        s1_field  <= field_d;
      end
    end
  end

  // ---------------- stage 2: round, saturate, negate, specials ----------------
  logic [NUM_LANES*n-1:0] res_d;
  logic [n-1:0]           rnd, mag;
  logic                   inc;

  always_comb begin
    res_d = '0;
    rnd   = '0;
    mag   = '0;
    inc   = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      inc = ~s1_rm & s1_guard[i] & (s1_sticky[i] | s1_field[i][0]);
      rnd = {1'b0, s1_field[i]} + n'(inc);
      // rnd[n-1] set means rounding carried out of maxpos
      if (s1_sat_hi[i] || rnd[n-1])        mag = MAXPOS;
      else if (s1_sat_lo[i] || rnd == '0)  mag = MINPOS;
      else                                 mag = rnd;
      if (s1_nar[i])        res_d[i*n +: n] = NAR;
      else if (s1_zero[i])  res_d[i*n +: n] = '0;
      else if (s1_sign[i])  res_d[i*n +: n] = -mag;
      else                  res_d[i*n +: n] = mag;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      tag_o       <= '0;
      result_o    <= '0;
    end else if (adv) begin
      out_valid_o <= s1_valid;
      if (s1_valid) begin
        tag_o    <= s1_tag;
        result_o <= res_d;
      end
    end
  end

endmodule

// File: tb/tb_posit_encoder_pipe.sv
// Directed testbench for posit_encoder_pipe (n=16, es=1, 4 lanes).
module tb_posit_encoder_pipe;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic        round_mode_i = 1'b0;
  logic [3:0]  tag_i = '0;
  logic [3:0]  nar_i = '0;
  logic [3:0]  sign_i = '0;
  logic [23:0] rg_exp_i = '0;
  logic [51:0] mant_norm_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [3:0]  tag_o;
  logic [63:0] result_o;

  int checks = 0;
  int failures = 0;

  posit_encoder_pipe dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .round_mode_i(round_mode_i), .tag_i(tag_i),
    .nar_i(nar_i), .sign_i(sign_i), .rg_exp_i(rg_exp_i), .mant_norm_i(mant_norm_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .tag_o(tag_o), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_lane(input int l, input logic nr, input logic sg, input int rg, input int m);
    nar_i[l] = nr;
    sign_i[l] = sg;
    rg_exp_i[l*6 +: 6] = 6'(rg);
    mant_norm_i[l*13 +: 13] = 13'(m);
  endtask

  // Present one beat at a negedge and wait (bounded) for its result.
  task automatic run_beat(input string nm, input logic [3:0] tg, input logic [63:0] exp);
    int lat;
    tag_i = tg;
    in_valid_i = 1'b1;
    out_ready_i = 1'b1;
    #1;
    check({nm, "_in_ready"}, 64'(in_ready_o), 64'(1));
    @(negedge clk_i);
    in_valid_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 8) begin
      @(negedge clk_i);
      lat++;
    end
    check({nm, "_latency"}, 64'(lat), 64'(2));
    check({nm, "_result"}, result_o, exp);
    check({nm, "_tag"}, 64'(tag_o), 64'(tg));
  endtask

  // Beat j of the stream tests: lane l = 0x4000|j<<8|l<<4, odd lanes negated.
  function automatic logic [63:0] stream_exp(input int j);
    logic [63:0] r;
    logic [15:0] p;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      p = 16'h4000 | 16'(j << 8) | 16'(l << 4);
      if (l % 2 == 1) p = -p;
      r[l*16 +: 16] = p;
    end
    return r;
  endfunction

  task automatic load_stream(input int j);
    for (int l = 0; l < 4; l++)
      set_lane(l, 1'b0, 1'(l % 2), 0, 'h1000 | (j << 8) | (l << 4));
    tag_i = 4'(j + 8);
    round_mode_i = 1'b0;
  endtask

  task automatic load_basic();
    set_lane(0, 1'b0, 1'b0, 0, 'h1000);
    set_lane(1, 1'b0, 1'b1, 0, 'h1000);
    set_lane(2, 1'b0, 1'b0, 0, 'h1800);
    set_lane(3, 1'b1, 1'b0, 0, 'h1000);
    round_mode_i = 1'b0;
  endtask

  initial begin
    int sent, rcv;
    logic ir_low;

    // reset state
    #1;
    check("rst_out_valid", 64'(out_valid_o), 64'(0));
    check("rst_result", result_o, 64'(0));
    check("rst_tag", 64'(tag_o), 64'(0));
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready_o), 64'(1));
    @(negedge clk_i);

    // basic encodes, NaR
    load_basic();
    run_beat("basic", 4'h5, {16'h8000, 16'h4800, 16'hC000, 16'h4000});

    // saturation
    set_lane(0, 1'b0, 1'b0, 31, 'h1000);
    set_lane(1, 1'b0, 1'b0, -32, 'h1000);
    set_lane(2, 1'b0, 1'b1, 31, 'h1000);
    set_lane(3, 1'b0, 1'b1, -32, 'h1000);
    run_beat("sat", 4'h6, {16'hFFFF, 16'h8001, 16'h0001, 16'h7FFF});

    // zero and RNE
    round_mode_i = 1'b0;
    set_lane(0, 1'b0, 1'b0, 5, 'h0000);
    set_lane(1, 1'b0, 1'b1, 5, 'h0000);
    set_lane(2, 1'b0, 1'b0, 2, 'h1001);
    set_lane(3, 1'b0, 1'b0, 2, 'h1003);
    run_beat("rne", 4'h7, {16'h6002, 16'h6000, 16'h0000, 16'h0000});

    // RTZ, negative scale, NaR wins over sign
    round_mode_i = 1'b1;
    set_lane(0, 1'b0, 1'b0, 2, 'h1003);
    set_lane(1, 1'b0, 1'b0, 2, 'h1001);
    set_lane(2, 1'b0, 1'b1, -2, 'h1000);
    set_lane(3, 1'b1, 1'b1, 2, 'h1000);
    run_beat("rtz", 4'h8, {16'h8000, 16'hE000, 16'h6000, 16'h6001});

    // regime edges k=+/-14 and rounding into maxpos
    round_mode_i = 1'b0;
    set_lane(0, 1'b0, 1'b0, 28, 'h1000);
    set_lane(1, 1'b0, 1'b0, -28, 'h1000);
    set_lane(2, 1'b0, 1'b1, -28, 'h1000);
    set_lane(3, 1'b0, 1'b0, 27, 'h1800);
    run_beat("edge", 4'h9, {16'h7FFF, 16'hFFFF, 16'h0001, 16'h7FFF});

    // backpressure: 6 back-to-back beats, out_ready low for cycles 3..5
    @(negedge clk_i);
    sent = 0;
    rcv = 0;
    ir_low = 1'b0;
    for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
      out_ready_i = !(cyc >= 3 && cyc <= 5);
      in_valid_i = (sent < 6);
      if (sent < 6) load_stream(sent);
      #1;
      if (out_valid_o && rcv < 6) begin
        check("bp_result", result_o, stream_exp(rcv));
        check("bp_tag", 64'(tag_o), 64'(rcv + 8));
      end
      if (out_valid_o && !in_ready_o) ir_low = 1'b1;
      if (out_valid_o && out_ready_i) rcv++;
      if (in_valid_i && in_ready_o) sent++;
      @(negedge clk_i);
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    check("bp_delivered", 64'(rcv), 64'(6));
    check("bp_in_ready_dropped", 64'(ir_low), 64'(1));
    @(negedge clk_i);
    @(negedge clk_i);
    check("bp_no_dup", 64'(out_valid_o), 64'(0));

    // bubble fill with S2 stalled
    out_ready_i = 1'b0;
    load_stream(1);
    in_valid_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    load_stream(2);
    in_valid_i = 1'b1;
    #1;
    check("bub_ir_one_full", 64'(in_ready_o), 64'(1));
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #1;
    check("bub_ir_both_full", 64'(in_ready_o), 64'(0));
    check("bub_first", result_o, stream_exp(1));
    check("bub_first_tag", 64'(tag_o), 64'(9));
    out_ready_i = 1'b1;
    @(negedge clk_i);
    #1;
    check("bub_second_valid", 64'(out_valid_o), 64'(1));
    check("bub_second", result_o, stream_exp(2));
    check("bub_second_tag", 64'(tag_o), 64'(10));
    @(negedge clk_i);
    check("bub_drained", 64'(out_valid_o), 64'(0));

    // reset with two beats in flight
    load_stream(3);
    in_valid_i = 1'b1;
    @(negedge clk_i);
    load_stream(4);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid_o), 64'(0));
    check("mid_rst_result", result_o, 64'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_rst_idle", 64'(out_valid_o), 64'(0));
    load_basic();
    run_beat("post_rst", 4'h3, {16'h8000, 16'h4800, 16'hC000, 16'h4000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
